// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with its own HI/LO register pair.
//
// Signed and unsigned multiply and divide are computed combinationally when
// an operation is launched. The result is held in shadow registers while the
// unit reports a fixed busy time, then committed to HI/LO in one edge.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - asynchronous active-high reset (HI/LO/busy/counter cleared)
//   start  - launch the operation selected by op (accepted only while idle)
//   op     - 00 mult, 01 multu, 10 div, 11 divu
//   a, b   - rs / rt operands
//   wr_hi  - mthi: HI <= a (idle only)
//   wr_lo  - mtlo: LO <= a (idle only)
//   flush  - abort any in-flight operation, drop all requests this cycle
//   busy   - operation in flight
//   hi, lo - architectural HI / LO registers (plain register outputs)
//
// Handshake: start is accepted on any rising edge where busy=0 and flush=0.
// busy rises the cycle after acceptance and stays high for exactly N cycles
// (N = MULT_CYCLES or DIV_CYCLES); start/wr_hi/wr_lo presented while busy=1
// are ignored, so the requester must hold them until busy falls. busy does
// not cover the acceptance cycle itself; consumers stall on (start | busy).
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] hi_q, hi_n, lo_q, lo_n;
    logic [WIDTH-1:0] res_hi_q, res_hi_n, res_lo_q, res_lo_n;
    // Cleared for divide by zero so completion leaves HI/LO untouched.
    logic             res_wr_q, res_wr_n;

    // Arithmetic datapath
    logic [2*WIDTH-1:0] prod;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, den, uq, ur, quo, rem;
    logic [WIDTH-1:0]   calc_hi, calc_lo;
    logic               calc_wr;

    always_comb begin
        if (op[0]) begin
            prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        end else begin
            prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        end

        // Signed divide works on magnitudes; the most-negative dividend has
        // the same bit pattern as its magnitude, so most-negative / -1 falls
        // out as quotient = most-negative, remainder = 0 with no special case.
        neg_a = ~op[0] & a[WIDTH-1];
        neg_b = ~op[0] & b[WIDTH-1];
        mag_a = neg_a ? -a : a;
        mag_b = neg_b ? -b : b;
        // Dummy divisor keeps the divider defined when b=0; the result is
        // discarded through calc_wr anyway.
        den   = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
        uq    = mag_a / den;
        ur    = mag_a % den;
        quo   = (neg_a ^ neg_b) ? -uq : uq;
        rem   = neg_a ? -ur : ur;

        if (op[1]) begin
            calc_hi = rem;
            calc_lo = quo;
            calc_wr = (b != '0);
        end else begin
            calc_hi = prod[2*WIDTH-1:WIDTH];
            calc_lo = prod[WIDTH-1:0];
            calc_wr = 1'b1;
        end
    end

    // FSM state register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_wr_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            hi_q     <= hi_n;
            lo_q     <= lo_n;
            res_hi_q <= res_hi_n;
            res_lo_q <= res_lo_n;
            res_wr_q <= res_wr_n;
        end
    end

    // FSM next state and register updates
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        hi_n     = hi_q;
        lo_n     = lo_q;
        res_hi_n = res_hi_q;
        res_lo_n = res_lo_q;
        res_wr_n = res_wr_q;

        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A write issued alongside start lands now and is
                    // overwritten when the operation commits.
                    if (wr_hi) hi_n = a;
                    if (wr_lo) lo_n = a;
                    if (start) begin
                        res_hi_n = calc_hi;
                        res_lo_n = calc_lo;
                        res_wr_n = calc_wr;
                        cnt_n    = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_n  = RUN;
                    end
                end
                RUN: begin
                    cnt_n = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_n = IDLE;
                        if (res_wr_q) begin
                            hi_n = res_hi_q;
                            lo_n = res_lo_q;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit (default parameters: WIDTH=32, 5/10 cycles).
module tb_md_unit;

    localparam int W  = 32;
    localparam int NM = 5;
    localparam int ND = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         wr_hi = 1'b0;
    logic         wr_lo = 1'b0;
    logic         flush = 1'b0;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    md_unit #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .flush(flush),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] pre_hi;
        logic [W-1:0] pre_lo;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vec[10];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle writing both HI and LO.
    task automatic preload(input logic [W-1:0] h, input logic [W-1:0] l);
        wr_hi = 1'b1; a = h;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b1; a = l;
        tick();
        wr_lo = 1'b0;
    endtask

    // Launch an op in the current cycle; return with the bench in the first
    // idle cycle after completion and the number of busy cycles seen.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, output int nbusy);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 50) begin
            nbusy++;
            tick();
        end
    endtask

    initial begin
        int nb;
        int expn;

        vec[0] = '{2'b00, 32'hFFFFFFFE, 32'h3,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vec[1] = '{2'b01, 32'hFFFFFFFE, 32'h3,        32'h0,  32'h0,  32'h00000002, 32'hFFFFFFFA};
        vec[2] = '{2'b10, 32'hFFFFFFF9, 32'h2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD};
        vec[3] = '{2'b11, 32'h7,        32'h0,        32'h11, 32'h22, 32'h00000011, 32'h00000022};
        vec[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h5,  32'h00000000, 32'h80000000};
        vec[5] = '{2'b11, 32'd100,      32'd7,        32'h0,  32'h0,  32'h00000002, 32'h0000000E};
        vec[6] = '{2'b10, 32'h7,        32'hFFFFFFFE, 32'h0,  32'h0,  32'h00000001, 32'hFFFFFFFD};
        vec[7] = '{2'b00, 32'h00010000, 32'h00010000, 32'h0,  32'h0,  32'h00000001, 32'h00000000};
        vec[8] = '{2'b10, 32'h5,        32'h0,        32'hAA, 32'hBB, 32'h000000AA, 32'h000000BB};
        vec[9] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,  32'hFFFFFFFE, 32'h00000001};

        // Reset asserted before any clock edge must act immediately.
        #2 reset = 1'b1;
        #1;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Table-driven operations.
        for (int i = 0; i < 10; i++) begin
            preload(vec[i].pre_hi, vec[i].pre_lo);
            run_op(vec[i].op, vec[i].a, vec[i].b, nb);
            expn = vec[i].op[1] ? ND : NM;
            check($sformatf("vec%0d_busy_cycles", i), W'(nb), W'(expn));
            check($sformatf("vec%0d_hi", i), hi, vec[i].exp_hi);
            check($sformatf("vec%0d_lo", i), lo, vec[i].exp_lo);
        end

        // mtlo while idle: visible the next cycle, HI untouched.
        preload(32'h99, 32'h0);
        wr_lo = 1'b1; a = 32'h1234;
        tick();
        wr_lo = 1'b0;
        check("mtlo_lo", lo, 32'h1234);
        check("mtlo_hi", hi, 32'h99);

        // start together with wr_hi: HI = a during the op, then the product.
        start = 1'b1; wr_hi = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        tick();
        start = 1'b0; wr_hi = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 50) begin
            nb++;
            check("start_wrhi_hold", hi, 32'd5);
            tick();
        end
        check("start_wrhi_cycles", W'(nb), W'(NM));
        check("start_wrhi_hi", hi, 32'd0);
        check("start_wrhi_lo", lo, 32'd30);

        // start / wr_hi / wr_lo while busy are ignored.
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        nb = 0;
        if (busy === 1'b1) nb++;
        tick();
        if (busy === 1'b1) nb++;
        start = 1'b1; op = 2'b00; wr_hi = 1'b1; wr_lo = 1'b1; a = 32'hDEAD; b = 32'h1;
        tick();
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        check("busy_ignore_hi", hi, 32'd0);
        check("busy_ignore_lo", lo, 32'd30);
        while (busy === 1'b1 && nb < 50) begin
            nb++;
            tick();
        end
        check("busy_ignore_cycles", W'(nb), W'(ND));
        check("busy_ignore_res_hi", hi, 32'd2);
        check("busy_ignore_res_lo", lo, 32'd14);

        // Flush in busy cycle 4 of a divide; a wr_hi in that cycle is dropped.
        preload(32'h55, 32'h66);
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd2;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("flush_pre_busy", {31'b0, busy}, 32'h1);
        flush = 1'b1; wr_hi = 1'b1; a = 32'hBAD;
        tick();
        flush = 1'b0; wr_hi = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'h0);
        check("flush_hi", hi, 32'h55);
        check("flush_lo", lo, 32'h66);
        for (int k = 0; k < ND + 2; k++) tick();
        check("flush_late_hi", hi, 32'h55);
        check("flush_late_lo", lo, 32'h66);
        check("flush_late_busy", {31'b0, busy}, 32'h0);

        // Back-to-back: second mult issued in the first idle cycle.
        run_op(2'b00, 32'd3, 32'd4, nb);
        check("b2b_first_cycles", W'(nb), W'(NM));
        check("b2b_first_lo", lo, 32'd12);
        run_op(2'b00, 32'd5, 32'd7, nb);
        check("b2b_second_cycles", W'(nb), W'(NM));
        check("b2b_second_lo", lo, 32'd35);

        // Reset mid-operation clears immediately and discards the result.
        preload(32'h77, 32'h88);
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
        tick();
        start = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        check("midreset_busy", {31'b0, busy}, 32'h0);
        check("midreset_hi", hi, 32'h0);
        check("midreset_lo", lo, 32'h0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < NM + 2; k++) tick();
        check("midreset_late_lo", lo, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
